// File: rtl/mem_dma_if.sv
// Native picorv32-style memory bus between an initiator (master) and a responder (slave).
interface mem_dma_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_dma_master.sv
// Word-granular copy/fill DMA engine acting as initiator on the native memory bus.
// Copy alternates READ/WRITE per word; fill issues back-to-back writes of a fixed pattern.
module mem_dma_master #(
  parameter int LEN_W            = 16,
  parameter bit ADDR_ALIGN_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_start,
  input  logic             cfg_fill,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [31:0]      cfg_fill_val,
  input  logic             cfg_abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic [LEN_W-1:0] words_done,
  mem_dma_if.master        mem
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_READ  = 2'd1;
  localparam logic [1:0]       ST_WRITE = 2'd2;
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [31:0]      src_ptr_r;
  logic [31:0]      dst_ptr_r;
  logic [LEN_W-1:0] remaining_r;
  logic [LEN_W-1:0] words_done_r;
  logic             fill_r;
  logic             abort_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             aborted_r;
  logic             mem_valid_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic [3:0]       mem_wstrb_r;

  logic hs_s;
  logic misalign_s;
  logic abort_s;
  logic last_s;

  assign hs_s       = mem_valid_r && mem.mem_ready;
  assign misalign_s = (cfg_dst[1:0] != 2'b00) || (!cfg_fill && (cfg_src[1:0] != 2'b00));
  assign abort_s    = abort_r || cfg_abort;
  assign last_s     = (remaining_r == LEN_ONE);

  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign aborted    = aborted_r;
  assign words_done = words_done_r;

  assign mem.mem_valid = mem_valid_r;
  assign mem.mem_instr = 1'b0;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign mem.mem_wstrb = mem_wstrb_r;

  // Job sequencing, bus request registers and status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      src_ptr_r    <= 32'd0;
      dst_ptr_r    <= 32'd0;
      remaining_r  <= LEN_ZERO;
      words_done_r <= LEN_ZERO;
      fill_r       <= 1'b0;
      abort_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      aborted_r    <= 1'b0;
      mem_valid_r  <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      mem_wstrb_r  <= 4'b0000;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          abort_r <= 1'b0;
          if (cfg_start) begin
            err_r        <= 1'b0;
            aborted_r    <= 1'b0;
            words_done_r <= LEN_ZERO;
            src_ptr_r    <= cfg_src;
            dst_ptr_r    <= cfg_dst;
            remaining_r  <= cfg_len;
            fill_r       <= cfg_fill;
            if (cfg_len == LEN_ZERO) begin
              done_r <= 1'b1;
            end else if (ADDR_ALIGN_CHECK && misalign_s) begin
              err_r  <= 1'b1;
              done_r <= 1'b1;
            end else begin
              busy_r      <= 1'b1;
              mem_valid_r <= 1'b1;
              if (cfg_fill) begin
                state_r     <= ST_WRITE;
                mem_addr_r  <= cfg_dst;
                mem_wdata_r <= cfg_fill_val;
                mem_wstrb_r <= 4'b1111;
              end else begin
                state_r     <= ST_READ;
                mem_addr_r  <= cfg_src;
                mem_wstrb_r <= 4'b0000;
              end
            end
          end
        end

        // A request is always outstanding while busy, so an abort lands on the next handshake.
        ST_READ: begin
          abort_r <= abort_s;
          if (hs_s) begin
            src_ptr_r <= src_ptr_r + 32'd4;
            if (abort_s) begin
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              aborted_r   <= 1'b1;
              mem_valid_r <= 1'b0;
              mem_wstrb_r <= 4'b0000;
            end else begin
              state_r     <= ST_WRITE;
              mem_addr_r  <= dst_ptr_r;
              mem_wdata_r <= mem.mem_rdata;
              mem_wstrb_r <= 4'b1111;
            end
          end
        end

        ST_WRITE: begin
          abort_r <= abort_s;
          if (hs_s) begin
            dst_ptr_r    <= dst_ptr_r + 32'd4;
            words_done_r <= words_done_r + LEN_ONE;
            remaining_r  <= remaining_r - LEN_ONE;
            if (last_s || abort_s) begin
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              aborted_r   <= !last_s;
              mem_valid_r <= 1'b0;
              mem_wstrb_r <= 4'b0000;
            end else if (fill_r) begin
              mem_addr_r <= dst_ptr_r + 32'd4;
            end else begin
              state_r     <= ST_READ;
              mem_addr_r  <= src_ptr_r;
              mem_wstrb_r <= 4'b0000;
            end
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          mem_valid_r <= 1'b0;
          mem_wstrb_r <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma_master.sv
// Directed self-checking bench for mem_dma_master with a configurable-latency memory responder.
module tb_mem_dma_master;

  logic        clk;
  logic        resetn;
  logic        cfg_start;
  logic        cfg_fill;
  logic [31:0] cfg_src;
  logic [31:0] cfg_dst;
  logic [15:0] cfg_len;
  logic [31:0] cfg_fill_val;
  logic        cfg_abort;
  logic        busy;
  logic        done;
  logic        err;
  logic        aborted;
  logic [15:0] words_done;

  mem_dma_if bus ();

  mem_dma_master #(.LEN_W(16), .ADDR_ALIGN_CHECK(1'b1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cfg_start    (cfg_start),
    .cfg_fill     (cfg_fill),
    .cfg_src      (cfg_src),
    .cfg_dst      (cfg_dst),
    .cfg_len      (cfg_len),
    .cfg_fill_val (cfg_fill_val),
    .cfg_abort    (cfg_abort),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .aborted      (aborted),
    .words_done   (words_done),
    .mem          (bus)
  );

  int checks = 0;
  int errors = 0;

  // Read data comes from rom (initial block only); writes land in ram (responder only).
  logic [31:0] rom [0:255];
  logic [31:0] ram [0:255];
  logic [3:0]  hs_log [0:255];
  int          hs_total;
  int          rd_cnt;
  int          wr_cnt;
  int          resp_delay;
  int          wait_cnt;
  logic        stab_viol;
  logic        pend_r;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  assign bus.mem_rdata = rom[bus.mem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.mem_ready <= 1'b0;
      wait_cnt      <= 0;
      pend_r        <= 1'b0;
    end else begin
      if (pend_r && (!bus.mem_valid || bus.mem_addr != last_addr ||
                     bus.mem_wdata != last_wdata || bus.mem_wstrb != last_wstrb))
        stab_viol <= 1'b1;
      pend_r     <= bus.mem_valid && !bus.mem_ready;
      last_addr  <= bus.mem_addr;
      last_wdata <= bus.mem_wdata;
      last_wstrb <= bus.mem_wstrb;
      if (bus.mem_valid && bus.mem_ready) begin
        bus.mem_ready    <= 1'b0;
        wait_cnt         <= 0;
        hs_log[hs_total[7:0]] <= bus.mem_wstrb;
        hs_total         <= hs_total + 1;
        if (bus.mem_wstrb == 4'b1111) begin
          ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
          wr_cnt <= wr_cnt + 1;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end else if (bus.mem_valid) begin
        if (wait_cnt >= resp_delay - 1) bus.mem_ready <= 1'b1;
        else wait_cnt <= wait_cnt + 1;
      end else begin
        bus.mem_ready <= 1'b0;
        wait_cnt      <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic fill, input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] len, input logic [31:0] val);
    @(negedge clk);
    cfg_fill = fill; cfg_src = src; cfg_dst = dst; cfg_len = len; cfg_fill_val = val;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      seen = (done === 1'b1);
    end
    cyc = seen ? n : -1;
  endtask

  initial begin
    int cyc;
    int rd0;
    int wr0;
    int hs0;
    hs_total = 0; rd_cnt = 0; wr_cnt = 0; resp_delay = 1; stab_viol = 1'b0;
    resetn = 1'b0; cfg_start = 1'b0; cfg_fill = 1'b0; cfg_src = 32'd0; cfg_dst = 32'd0;
    cfg_len = 16'd0; cfg_fill_val = 32'd0; cfg_abort = 1'b0;
    rom[8'h40] = 32'h11; rom[8'h41] = 32'h22; rom[8'h42] = 32'h33; rom[8'h43] = 32'h44;
    rom[8'h50] = 32'hA5A5_0001; rom[8'h51] = 32'h5A5A_0002;
    for (int i = 68; i < 72; i++) rom[i] = 32'h1000 + i;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", bus.mem_valid, 1'b0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wstrb", bus.mem_wstrb, 4'd0);
    check("rst_words", words_done, 16'd0);
    check("rst_instr", bus.mem_instr, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Copy 4 words 0x100 -> 0x200
    rd0 = rd_cnt; wr0 = wr_cnt; hs0 = hs_total;
    start_job(1'b0, 32'h100, 32'h200, 16'd4, 32'd0);
    check("cp_busy", busy, 1'b1);
    check("cp_valid", bus.mem_valid, 1'b1);
    check("cp_addr0", bus.mem_addr, 32'h100);
    check("cp_wstrb0", bus.mem_wstrb, 4'b0000);
    wait_done(40, cyc);
    check("cp_latency", cyc, 16);
    check("cp_words", words_done, 16'd4);
    check("cp_busy_end", busy, 1'b0);
    check("cp_m80", ram[8'h80], 32'h11);
    check("cp_m81", ram[8'h81], 32'h22);
    check("cp_m82", ram[8'h82], 32'h33);
    check("cp_m83", ram[8'h83], 32'h44);
    check("cp_rd", rd_cnt - rd0, 4);
    check("cp_wr", wr_cnt - wr0, 4);
    for (int i = 0; i < 8; i++)
      check($sformatf("cp_alt%0d", i), hs_log[hs0 + i], (i % 2 == 0) ? 4'b0000 : 4'b1111);
    @(posedge clk);
    #1;
    check("cp_done_pulse", done, 1'b0);
    check("cp_valid_end", bus.mem_valid, 1'b0);

    // Fill 3 words at 0x300
    rd0 = rd_cnt; wr0 = wr_cnt;
    start_job(1'b1, 32'h0, 32'h300, 16'd3, 32'hDEADBEEF);
    check("fl_wstrb0", bus.mem_wstrb, 4'b1111);
    wait_done(40, cyc);
    check("fl_latency", cyc, 6);
    check("fl_mC0", ram[8'hC0], 32'hDEADBEEF);
    check("fl_mC1", ram[8'hC1], 32'hDEADBEEF);
    check("fl_mC2", ram[8'hC2], 32'hDEADBEEF);
    check("fl_rd", rd_cnt - rd0, 0);
    check("fl_wr", wr_cnt - wr0, 3);
    check("fl_words", words_done, 16'd3);

    // Zero length, then misaligned destination
    hs0 = hs_total;
    start_job(1'b0, 32'h100, 32'h200, 16'd0, 32'd0);
    check("z_done", done, 1'b1);
    check("z_valid", bus.mem_valid, 1'b0);
    check("z_err", err, 1'b0);
    check("z_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("z_done_clr", done, 1'b0);
    check("z_valid2", bus.mem_valid, 1'b0);
    start_job(1'b0, 32'h100, 32'h202, 16'd2, 32'd0);
    check("mis_done", done, 1'b1);
    check("mis_err", err, 1'b1);
    check("mis_valid", bus.mem_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mis_err_sticky", err, 1'b1);
    check("mis_valid2", bus.mem_valid, 1'b0);
    check("z_no_traffic", hs_total - hs0, 0);

    // Slow responder, copy 2 words 0x140 -> 0x280
    resp_delay = 3;
    stab_viol = 1'b0;
    start_job(1'b0, 32'h140, 32'h280, 16'd2, 32'd0);
    check("sl_err_clr", err, 1'b0);
    wait_done(100, cyc);
    check("sl_latency", cyc, 16);
    check("sl_mA0", ram[8'hA0], 32'hA5A5_0001);
    check("sl_mA1", ram[8'hA1], 32'h5A5A_0002);
    check("sl_stable", stab_viol, 1'b0);
    resp_delay = 1;

    // Abort during second word's READ of an 8-word copy
    rd0 = rd_cnt; wr0 = wr_cnt;
    start_job(1'b0, 32'h100, 32'h240, 16'd8, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("ab_words_mid", words_done, 16'd1);
    check("ab_read_phase", bus.mem_wstrb, 4'b0000);
    cfg_abort = 1'b1;
    wait_done(40, cyc);
    cfg_abort = 1'b0;
    check("ab_latency", cyc, 2);
    check("ab_aborted", aborted, 1'b1);
    check("ab_words", words_done, 16'd1);
    check("ab_busy", busy, 1'b0);
    check("ab_rd", rd_cnt - rd0, 2);
    check("ab_wr", wr_cnt - wr0, 1);
    check("ab_m90", ram[8'h90], 32'h11);
    @(posedge clk);
    #1;
    check("ab_valid_end", bus.mem_valid, 1'b0);

    // Reset mid-WRITE, then a clean 2-word copy
    start_job(1'b0, 32'h100, 32'h2C0, 16'd4, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rw_in_write", bus.mem_wstrb, 4'b1111);
    #2;
    resetn = 1'b0;
    #1;
    check("rw_valid", bus.mem_valid, 1'b0);
    check("rw_busy", busy, 1'b0);
    check("rw_wstrb", bus.mem_wstrb, 4'b0000);
    check("rw_aborted_clr", aborted, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    wr0 = wr_cnt;
    start_job(1'b0, 32'h100, 32'h2E0, 16'd2, 32'd0);
    wait_done(40, cyc);
    check("rw2_latency", cyc, 8);
    check("rw2_mB8", ram[8'hB8], 32'h11);
    check("rw2_mB9", ram[8'hB9], 32'h22);
    check("rw2_words", words_done, 16'd2);
    check("rw2_wr", wr_cnt - wr0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
